// File: rtl/puntaje_ctrl_pkg.sv
// puntaje_ctrl_pkg: game state codes, 7-segment digit codes and BCD helpers
// shared by puntaje_ctrl, its seg7_bcd encoder and the display multiplexer.
package puntaje_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_WLCM = 3'd1,
        ST_CH   = 3'd2,
        ST_GAME = 3'd3,
        ST_WL   = 3'd4,
        ST_PA   = 3'd5
    } state_e;

    // Segment order {a,b,c,d,e,f,g}, bit 6 = a; index 0 is digit 0
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    // Undefined codes 6-7 collapse onto OFF
    function automatic state_e norm_state(input logic [2:0] code);
        return (code > 3'd5) ? ST_OFF : state_e'(code);
    endfunction

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/puntaje_ctrl_if.sv
// puntaje_ctrl_if: game-state/point inputs and score/display outputs of puntaje_ctrl.
// Record ports exist only when PUNTAJE_RECORD_EN is defined.
interface puntaje_ctrl_if;

    logic [2:0]  presente;
    logic        punto;
    logic [20:0] display_puntaje;
    logic [11:0] score_bcd;
    logic        saturado;
`ifdef PUNTAJE_RECORD_EN
    logic [11:0] record_bcd;
    logic [20:0] display_record;

    modport master (output presente, punto,
                    input  display_puntaje, score_bcd, saturado, record_bcd, display_record);
    modport slave  (input  presente, punto,
                    output display_puntaje, score_bcd, saturado, record_bcd, display_record);
`else
    modport master (output presente, punto,
                    input  display_puntaje, score_bcd, saturado);
    modport slave  (input  presente, punto,
                    output display_puntaje, score_bcd, saturado);
`endif

endinterface

// File: rtl/puntaje_ctrl_seg7_bcd.sv
// seg7_bcd: combinational BCD digit to active-high 7-segment code with blanking.
module seg7_bcd
    import puntaje_ctrl_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb o_seg = (i_blank || i_digit > 4'd9) ? SEG_BLANK : SEG_DIGITS[i_digit];

endmodule

// File: rtl/puntaje_ctrl.sv
// puntaje_ctrl: BCD score counter with saturation, new-game clear and registered
// 7-segment display with leading-zero blanking. Optional high score: PUNTAJE_RECORD_EN.
module puntaje_ctrl
    import puntaje_ctrl_pkg::*;
#(
    parameter int MAX_SCORE = 999
) (
    input  logic           clk,
    input  logic           rst_n,
    puntaje_ctrl_if.slave  bus
);

    localparam logic [11:0] MAX_BCD = to_bcd(MAX_SCORE);

    state_e      r_prev;
    state_e      w_state;
    logic        r_punto_q;
    logic        r_armed;
    logic        r_edge;
    logic [11:0] r_score;
    logic [11:0] w_score_inc;
    logic [11:0] w_score_nxt;
    logic [20:0] r_disp;
    logic [6:0]  w_seg_h;
    logic [6:0]  w_seg_t;
    logic [6:0]  w_seg_u;
    logic        w_clear;
    logic        w_sat;

    always_comb begin
        w_state = norm_state(bus.presente);
        w_sat = (r_score == MAX_BCD);
        w_clear = (w_state == ST_OFF) || (w_state == ST_CH && r_prev != ST_CH);
        w_score_inc[3:0] = (r_score[3:0] == 4'd9) ? 4'd0 : r_score[3:0] + 4'd1;
        w_score_inc[7:4] = (r_score[3:0] != 4'd9) ? r_score[7:4] :
                           (r_score[7:4] == 4'd9) ? 4'd0 : r_score[7:4] + 4'd1;
        w_score_inc[11:8] = (r_score[7:0] == 8'h99) ? r_score[11:8] + 4'd1 : r_score[11:8];
        w_score_nxt = w_clear ? 12'h000 :
                      (r_edge && w_state == ST_GAME && !w_sat) ? w_score_inc : r_score;
    end

    // r_armed blocks a punto that is already high when reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= ST_OFF;
            r_punto_q <= 1'b0;
            r_armed   <= 1'b0;
            r_edge    <= 1'b0;
            r_score   <= 12'h000;
            r_disp    <= {SEG_BLANK, SEG_BLANK, SEG_DIGITS[0]};
        end else begin
            r_prev    <= w_state;
            r_punto_q <= bus.punto;
            r_armed   <= r_armed | ~bus.punto;
            r_edge    <= bus.punto & ~r_punto_q & r_armed;
            r_score   <= w_score_nxt;
            r_disp    <= {w_seg_h, w_seg_t, w_seg_u};
        end
    end

    seg7_bcd u_seg_h (.i_digit(r_score[11:8]), .i_blank(r_score[11:8] == 4'd0), .o_seg(w_seg_h));
    seg7_bcd u_seg_t (.i_digit(r_score[7:4]),  .i_blank(r_score[11:4] == 8'h00), .o_seg(w_seg_t));
    seg7_bcd u_seg_u (.i_digit(r_score[3:0]),  .i_blank(1'b0),                   .o_seg(w_seg_u));

    assign bus.score_bcd       = r_score;
    assign bus.saturado        = w_sat;
    assign bus.display_puntaje = r_disp;

`ifdef PUNTAJE_RECORD_EN
    logic [11:0] r_record;
    logic [20:0] r_disp_rec;
    logic [6:0]  w_rec_h;
    logic [6:0]  w_rec_t;
    logic [6:0]  w_rec_u;

    // Record captures the score on the cycle the game enters WL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_record   <= 12'h000;
            r_disp_rec <= {SEG_BLANK, SEG_BLANK, SEG_DIGITS[0]};
        end else begin
            if (w_state == ST_WL && r_prev != ST_WL && r_score > r_record)
                r_record <= r_score;
            r_disp_rec <= {w_rec_h, w_rec_t, w_rec_u};
        end
    end

    seg7_bcd u_rec_h (.i_digit(r_record[11:8]), .i_blank(r_record[11:8] == 4'd0), .o_seg(w_rec_h));
    seg7_bcd u_rec_t (.i_digit(r_record[7:4]),  .i_blank(r_record[11:4] == 8'h00), .o_seg(w_rec_t));
    seg7_bcd u_rec_u (.i_digit(r_record[3:0]),  .i_blank(1'b0),                    .o_seg(w_rec_u));

    assign bus.record_bcd     = r_record;
    assign bus.display_record = r_disp_rec;
`endif

endmodule

// File: tb/tb_puntaje_ctrl.sv
// tb_puntaje_ctrl: scoreboard bench for puntaje_ctrl (MAX_SCORE 999 and 12 instances);
// record checks are compiled in with PUNTAJE_RECORD_EN.
module tb_puntaje_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puntaje_ctrl_if bus();
    puntaje_ctrl_if bus_s();
    assign bus_s.presente = bus.presente;
    assign bus_s.punto    = bus.punto;

    puntaje_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    puntaje_ctrl #(.MAX_SCORE(12)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    int n_cmp = 0;
    int n_bad = 0;
    int exp_score = 0;
    int exp_s = 0;
    int m_prev = 0;
    int m_state = 0;
    int exp_q[$];
    int exp_sq[$];
    logic [6:0] tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    function automatic logic [11:0] bcd(int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [20:0] disp_of(int s);
        int h, t, u;
        h = s / 100;
        t = (s / 10) % 10;
        u = s % 10;
        return {(h == 0) ? 7'h00 : tbl[h], (h == 0 && t == 0) ? 7'h00 : tbl[t], tbl[u]};
    endfunction

    // One punto pulse; the model's expected scores are queued for the caller to check
    task automatic pulse(int high = 3);
        @(negedge clk) bus.punto = 1'b1;
        repeat (high) @(negedge clk);
        bus.punto = 1'b0;
        repeat (3) @(negedge clk);
        if (m_state == 3) begin
            if (exp_score < 999) exp_score++;
            if (exp_s < 12) exp_s++;
        end
        exp_q.push_back(exp_score);
        exp_sq.push_back(exp_s);
    endtask

    task automatic set_state(int s);
        int n;
        n = (s > 5) ? 0 : s;
        @(negedge clk) bus.presente = 3'(s);
        if (n == 0 || (n == 2 && m_prev != 2)) begin
            exp_score = 0;
            exp_s = 0;
        end
        m_prev = n;
        m_state = n;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.punto = 1'b0;
        bus.presente = 3'd0;
        exp_score = 0;
        exp_s = 0;
        m_prev = 0;
        m_state = 0;
        exp_q.delete();
        exp_sq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.punto = 1'b0;
        bus.presente = 3'd3;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.score_bcd !== 12'h000) begin
            n_bad++; $display("FAIL reset_score got %h want 000", bus.score_bcd);
        end
        n_cmp++;
        if (bus.saturado !== 1'b0) begin
            n_bad++; $display("FAIL reset_sat got %b want 0", bus.saturado);
        end
        n_cmp++;
        if (bus.display_puntaje !== 21'h00007E) begin
            n_bad++; $display("FAIL reset_disp got %h want 00007e", bus.display_puntaje);
        end
        n_cmp++;
        if (bus_s.saturado !== 1'b0) begin
            n_bad++; $display("FAIL reset_sat12 got %b want 0", bus_s.saturado);
        end
    endtask

    task automatic test_count5();
        int e;
        do_reset();
        set_state(3);
        for (int i = 0; i < 5; i++) begin
            pulse();
            e = exp_q.pop_front();
            void'(exp_sq.pop_front());
            n_cmp++;
            if (bus.score_bcd !== bcd(e)) begin
                n_bad++; $display("FAIL count5_score got %h want %h", bus.score_bcd, bcd(e));
            end
            n_cmp++;
            if (bus.display_puntaje !== disp_of(e)) begin
                n_bad++; $display("FAIL count5_disp got %h want %h", bus.display_puntaje, disp_of(e));
            end
        end
        n_cmp++;
        if (bus.display_puntaje !== {7'h00, 7'h00, 7'h5B}) begin
            n_bad++; $display("FAIL count5_final_disp got %h want 00005b", bus.display_puntaje);
        end
    endtask

    task automatic test_carry();
        int e;
        for (int i = 6; i <= 100; i++) begin
            pulse();
            e = exp_q.pop_front();
            void'(exp_sq.pop_front());
            n_cmp++;
            if (bus.score_bcd !== bcd(e)) begin
                n_bad++; $display("FAIL carry_score got %h want %h", bus.score_bcd, bcd(e));
            end
            n_cmp++;
            if (bus.display_puntaje !== disp_of(e)) begin
                n_bad++; $display("FAIL carry_disp got %h want %h", bus.display_puntaje, disp_of(e));
            end
            if (e == 10) begin
                n_cmp++;
                if (bus.display_puntaje !== {7'h00, 7'h30, 7'h7E}) begin
                    n_bad++; $display("FAIL carry_010 got %h want 00187e", bus.display_puntaje);
                end
            end
            if (e == 100) begin
                n_cmp++;
                if (bus.score_bcd !== 12'h100 || bus.display_puntaje !== {7'h30, 7'h7E, 7'h7E}) begin
                    n_bad++; $display("FAIL carry_100 got %h/%h want 100/%h",
                                      bus.score_bcd, bus.display_puntaje, {7'h30, 7'h7E, 7'h7E});
                end
            end
        end
    endtask

    task automatic test_saturate();
        int es;
        do_reset();
        set_state(3);
        for (int i = 0; i < 15; i++) begin
            pulse();
            void'(exp_q.pop_front());
            es = exp_sq.pop_front();
            n_cmp++;
            if (bus_s.score_bcd !== bcd(es) || bus_s.saturado !== (es == 12)) begin
                n_bad++; $display("FAIL sat_step got %h/%b want %h/%b",
                                  bus_s.score_bcd, bus_s.saturado, bcd(es), es == 12);
            end
        end
        n_cmp++;
        if (bus_s.score_bcd !== 12'h012 || bus_s.saturado !== 1'b1) begin
            n_bad++; $display("FAIL sat_final got %h/%b want 012/1", bus_s.score_bcd, bus_s.saturado);
        end
        set_state(2);
        set_state(3);
        pulse(20);
        es = exp_q.pop_front();
        void'(exp_sq.pop_front());
        n_cmp++;
        if (bus.score_bcd !== bcd(es)) begin
            n_bad++; $display("FAIL held_high got %h want %h", bus.score_bcd, bcd(es));
        end
    endtask

    task automatic test_hold();
        int e;
        for (int i = 0; i < 36; i++) begin
            pulse();
            e = exp_q.pop_front();
            void'(exp_sq.pop_front());
        end
        n_cmp++;
        if (bus.score_bcd !== 12'h037) begin
            n_bad++; $display("FAIL hold_pre got %h want 037", bus.score_bcd);
        end
        set_state(5);
        for (int i = 0; i < 4; i++) begin
            pulse();
            e = exp_q.pop_front();
            void'(exp_sq.pop_front());
            n_cmp++;
            if (bus.score_bcd !== bcd(e)) begin
                n_bad++; $display("FAIL hold_pa got %h want %h", bus.score_bcd, bcd(e));
            end
        end
        set_state(3);
        pulse();
        e = exp_q.pop_front();
        void'(exp_sq.pop_front());
        n_cmp++;
        if (bus.score_bcd !== bcd(e)) begin
            n_bad++; $display("FAIL resume_game got %h want %h", bus.score_bcd, bcd(e));
        end
        @(negedge clk);
        bus.punto = 1'b1;
        bus.presente = 3'd2;
        exp_score = 0;
        exp_s = 0;
        m_prev = 2;
        m_state = 2;
        repeat (3) @(negedge clk);
        bus.punto = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.score_bcd !== bcd(exp_score) || bus.display_puntaje !== disp_of(exp_score)) begin
            n_bad++; $display("FAIL ch_with_edge got %h/%h want %h/%h",
                              bus.score_bcd, bus.display_puntaje, bcd(exp_score), disp_of(exp_score));
        end
        set_state(3);
        pulse();
        pulse();
        void'(exp_q.pop_front());
        void'(exp_sq.pop_front());
        void'(exp_q.pop_front());
        void'(exp_sq.pop_front());
        set_state(4);
        pulse();
        e = exp_q.pop_front();
        void'(exp_sq.pop_front());
        n_cmp++;
        if (bus.score_bcd !== bcd(e)) begin
            n_bad++; $display("FAIL hold_wl got %h want %h", bus.score_bcd, bcd(e));
        end
        set_state(7);
        n_cmp++;
        if (bus.score_bcd !== bcd(exp_score)) begin
            n_bad++; $display("FAIL code7_clear got %h want %h", bus.score_bcd, bcd(exp_score));
        end
    endtask

    task automatic test_async_reset();
        int e;
        do_reset();
        set_state(3);
        for (int i = 0; i < 250; i++) begin
            pulse();
            e = exp_q.pop_front();
            void'(exp_sq.pop_front());
        end
        n_cmp++;
        if (bus.score_bcd !== bcd(e)) begin
            n_bad++; $display("FAIL pre_async got %h want %h", bus.score_bcd, bcd(e));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.punto = 1'b1;
        #1;
        n_cmp++;
        if (bus.score_bcd !== 12'h000 || bus.saturado !== 1'b0 || bus.display_puntaje !== 21'h00007E) begin
            n_bad++; $display("FAIL async_reset got %h/%b/%h want 000/0/00007e",
                              bus.score_bcd, bus.saturado, bus.display_puntaje);
        end
        exp_score = 0;
        exp_s = 0;
        m_prev = 3;
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.score_bcd !== 12'h000) begin
            n_bad++; $display("FAIL high_at_release got %h want 000", bus.score_bcd);
        end
        bus.punto = 1'b0;
        repeat (2) @(negedge clk);
        pulse();
        e = exp_q.pop_front();
        void'(exp_sq.pop_front());
        n_cmp++;
        if (bus.score_bcd !== bcd(e)) begin
            n_bad++; $display("FAIL after_release got %h want %h", bus.score_bcd, bcd(e));
        end
    endtask

`ifdef PUNTAJE_RECORD_EN
    task automatic test_record();
        int rec;
        do_reset();
        rec = 0;
        set_state(3);
        repeat (42) pulse();
        set_state(4);
        if (exp_score > rec) rec = exp_score;
        n_cmp++;
        if (bus.record_bcd !== bcd(rec)) begin
            n_bad++; $display("FAIL record_first got %h want %h", bus.record_bcd, bcd(rec));
        end
        set_state(2);
        set_state(3);
        repeat (17) pulse();
        set_state(4);
        if (exp_score > rec) rec = exp_score;
        n_cmp++;
        if (bus.record_bcd !== bcd(rec)) begin
            n_bad++; $display("FAIL record_keep got %h want %h", bus.record_bcd, bcd(rec));
        end
        n_cmp++;
        if (bus.display_record !== {7'h00, 7'h33, 7'h6D}) begin
            n_bad++; $display("FAIL record_disp got %h want 0019ed", bus.display_record);
        end
        exp_q.delete();
        exp_sq.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_count5();
        test_carry();
        test_saturate();
        test_hold();
        test_async_reset();
`ifdef PUNTAJE_RECORD_EN
        test_record();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/puntaje_ctrl.md
PUNTAJE_CTRL -- requirements
Module: puntaje_ctrl

Interface
REQ-001 Parameter MAX_SCORE, default 999, saturation value of the score (decimal, 1..999).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 presente  input  3  game state code: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5.
REQ-005 punto  input  1  level from the obstacle stage, high while an obstacle is being cleared; one point per rising edge.
REQ-006 display_puntaje  output  21  three 7-segment codes {hundreds[20:14], tens[13:7], units[6:0]}, active-high.
REQ-007 score_bcd  output  12  current score as 3 BCD digits {h,t,u}.
REQ-008 saturado  output  1  high while the score equals MAX_SCORE.

Function
REQ-009 Segment code bit order is {a,b,c,d,e,f,g}, bit 6 = a; digits 0-9 = 7E,30,6D,79,33,5B,5F,70,7F,7B (hex); blank = 00.
REQ-010 Rising edge of punto: registered punto_q; an edge is punto & ~punto_q, detected in the cycle punto is first sampled high.
REQ-011 Score increments by exactly 1 in the cycle after an edge is detected, only when presente==GAME; edges in any other state are discarded and not queued.
REQ-012 BCD increment: units 9 wraps to 0 with carry into tens; tens 9 wraps to 0 with carry into hundreds; no digit ever holds a value above 9.
REQ-013 At MAX_SCORE further edges are ignored; score holds; saturado=1.
REQ-014 Score clears to 000 in the cycle after presente changes to CH from any other value (new game); clear has priority over a simultaneous increment.
REQ-015 Score holds unchanged in WL, PA, WLCM and GAME without edges; in OFF it clears to 000.
REQ-016 display_puntaje is registered: it reflects score_bcd one cycle after score_bcd changes (total edge-to-display latency 3 cycles from punto high).
REQ-017 Leading-zero blanking: hundreds is blank when 0; tens is blank when hundreds and tens are both 0; units is always shown.
REQ-018 presente values 6-7 behave as OFF.

Reset
REQ-019 While rst_n=0: score_bcd=000, punto_q=0, saturado=0, display_puntaje={00,00,7E}, prev-state register=OFF.
REQ-020 Deassertion mid-game resumes with score 000; a punto already high at deassertion does not count until it falls and rises again.

Configuration
REQ-021 Macro PUNTAJE_RECORD_EN: when defined, adds output record_bcd (12 bits) and display_record (21 bits, same encoding/blanking); record updates to score on entry to WL when score > record, resets to 000 only on rst_n.
REQ-022 Without PUNTAJE_RECORD_EN, those ports and registers do not exist; all other behaviour is identical.

Structure
REQ-023 Shared package holds state codes OFF..PA, the 7-segment digit constants and the blank code; this block and the display multiplexer both use it.
REQ-024 One sub-module, seg7_bcd: combinational BCD digit to segment-code encoder with a blank input, instantiated three times (six with PUNTAJE_RECORD_EN).

Verification
REQ-025 Reset, then presente=GAME, 5 punto pulses of 3 cycles each -> score_bcd=005, display_puntaje={00,00,5B}.
REQ-026 Preload to 099 via pulses, one more pulse -> score_bcd=100, display={30,7E,7E}; from 009 one pulse -> 010, display={00,30,7E}.
REQ-027 MAX_SCORE=12, 15 pulses -> score 012, saturado=1; punto held high for 20 cycles counts once.
REQ-028 Score 037, presente GAME->PA, 4 pulses -> score stays 037; PA->GAME, 1 pulse -> 038; presente->CH in the same cycle as an edge -> 000.
REQ-029 rst_n pulsed low asynchronously mid-count (between clock edges) at score 250 -> outputs at reset values immediately, before next clk edge.
REQ-030 With PUNTAJE_RECORD_EN: game ends at 042 (WL) -> record 042; next game ends at 017 -> record stays 042, display_record={00,33,6D}.
